microseq_ctrl: RTL and testbench
================================

Name: microseq_ctrl

Overview:
- Microprogram sequencer for the microprogrammed CPU. Generates the control-store address (micro-PC) every cycle.
- Inputs: sequencing fields of the current microword, ALU flags, and the opcode-map address.
- Provides conditional jump, subroutine call/return through a small return stack, a loop counter, and opcode dispatch.
- Sits between the control ROM output register and the ROM address input.

Parameters:
ADDR_W, 8, micro-PC / control-store address width
CNT_W, 8, loop counter width (CNT_W <= ADDR_W)
STACK_DEPTH, 4, return-stack entries (power of 2, >= 2)
RESET_VEC, 0, micro-PC value after reset and after JZ

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low; 0 clears all state immediately
stall  in  1  1 = hold all state this cycle (upc, sp, counter, stack)
seq_op  in  3  sequencing op of current microword
cond_sel  in  2  0 = always true, 1 = zero, 2 = carry, 3 = neg
cond_inv  in  1  invert selected condition
flags  in  3  {neg, carry, zero} from ALU flag register
br_addr  in  ADDR_W  branch/count field of current microword
map_addr  in  ADDR_W  dispatch address from opcode map ROM
upc  out  ADDR_W  current micro-PC (registered)
stk_depth  out  clog2(STACK_DEPTH)+1  number of valid stack entries
cnt_zero  out  1  loop counter == 0
err  out  1  stack error flag (see Optional Feature)

Behaviour:
- Reset (reset = 0, asynchronous):
  - upc = RESET_VEC, sp = 0, counter = 0, err = 0.
  - Stack contents are don't-care.
  - Release is synchronous to the next clock edge.
- Timing:
  - seq_op, cond_sel, cond_inv, br_addr and map_addr are the microword addressed by the current upc.
  - All inputs are sampled on a rising edge; the new upc is visible one cycle later.
  - There is no combinational path from inputs to upc.
- Condition: cond = (cond_sel == 0 ? 1 : flags[cond_sel-1]) XOR cond_inv.
- inc = upc + 1, modulo 2^ADDR_W. Address 2^ADDR_W-1 wraps to 0.
- seq_op:
  - 0 CONT: upc <= inc.
  - 1 JMAP: upc <= map_addr.
  - 2 CJP: upc <= cond ? br_addr : inc.
  - 3 CJS: if cond, push inc and upc <= br_addr; else upc <= inc.
  - 4 CRTN: if cond, upc <= top and pop; else upc <= inc.
  - 5 LDCT: counter <= br_addr[CNT_W-1:0]; upc <= inc.
  - 6 RPCT: if counter != 0, counter <= counter-1 and upc <= br_addr; else upc <= inc.
    - A counter loaded with N causes N jumps, then falls through.
  - 7 JZ: upc <= RESET_VEC; sp <= 0; counter unchanged.
- Stack:
  - LIFO; sp counts from 0 to STACK_DEPTH.
  - stk_depth = sp.
  - A push writes entry[sp] and increments sp.
  - A pop reads entry[sp-1] and decrements sp.
- Boundaries (macro off):
  - CJS taken with sp == STACK_DEPTH: overwrites entry[STACK_DEPTH-1], sp unchanged, jump still taken.
  - CRTN taken with sp == 0: behaves as CONT.
- stall = 1: everything holds, including a pending push/pop and a counter decrement. stall overrides seq_op.
- reset asserted mid-stall or mid-loop: the asynchronous clear wins unconditionally.
- cnt_zero is combinational from the counter register.

Optional Feature:
- Macro: MICROSEQ_STACK_CHECK_EN.
- Defined:
  - A taken CJS with sp == STACK_DEPTH, or a taken CRTN with sp == 0, sets err = 1 (sticky).
  - Those ops, and every subsequent op, are ignored: upc, sp and counter freeze.
  - Only reset clears err.
- Not defined:
  - err is tied to 0.
  - Boundary behaviour is as listed above.
  - No freeze logic is synthesised.

Test Plan:
1. Reset: hold reset = 0 for 50 us with clock running, then release. Required: upc = 0 during reset; after release, CONT ops give upc 0, 1, 2, 3 on consecutive edges; err = 0; stk_depth = 0.
2. Conditional jump: at upc = 5 apply CJP, cond_sel = 1, br_addr = 0x40.
   - flags = 3'b001: next upc = 0x40.
   - flags = 3'b000: next upc = 6.
   - cond_inv = 1 reverses both outcomes.
3. Call/return: at upc = 0x10 apply CJS always with br_addr = 0x80. Required: upc = 0x80, stk_depth = 1. Then CRTN always gives upc = 0x11, stk_depth = 0. Nest 4 calls, then 4 returns; return addresses come back in LIFO order.
4. Loop: LDCT with br_addr = 3, then RPCT with br_addr = 0x20 at upc = 0x21. Required: three jumps to 0x20, then fall-through to 0x22; cnt_zero = 1 afterwards.
5. Dispatch and wrap:
   - JMAP with map_addr = 0x9C gives upc = 0x9C.
   - CONT at upc = 0xFF gives upc = 0x00.
   - stall = 1 for 3 cycles during RPCT: upc and counter unchanged.
6. Stack overflow and underflow, checked in both builds:
   - 5th nested CJS:
     - Macro off: jump still taken, stk_depth stays 4.
     - Macro on: err = 1 and upc frozen until reset = 0.
   - CRTN when empty:
     - Macro off: acts as CONT.
     - Macro on: err = 1.

Source files
------------

// File: rtl/microseq_ctrl.sv
// microseq_ctrl: micro-PC sequencer with return stack, loop counter and dispatch.
// Define MICROSEQ_STACK_CHECK_EN for a sticky stack error that freezes the sequencer.
module microseq_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int CNT_W       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   seq_op,
  input  logic [1:0]                   cond_sel,
  input  logic                         cond_inv,
  input  logic [2:0]                   flags,
  input  logic [ADDR_W-1:0]            br_addr,
  input  logic [ADDR_W-1:0]            map_addr,
  output logic [ADDR_W-1:0]            upc,
  output logic [$clog2(STACK_DEPTH):0] stk_depth,
  output logic                         cnt_zero,
  output logic                         err
);

  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int SPW = IW + 1;

  typedef enum logic [2:0] {
    OP_CONT = 3'd0,
    OP_JMAP = 3'd1,
    OP_CJP  = 3'd2,
    OP_CJS  = 3'd3,
    OP_CRTN = 3'd4,
    OP_LDCT = 3'd5,
    OP_RPCT = 3'd6,
    OP_JZ   = 3'd7
  } op_e;

  op_e               op;
  logic [ADDR_W-1:0] upc_q, upc_d, inc;
  logic [SPW-1:0]    sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [IW-1:0]     wr_idx, rd_idx;
  logic              push, full, empty;
  logic              sel_flag, cond, hold;

  assign op     = op_e'(seq_op);
  assign inc    = upc_q + 1'b1;
  assign full   = (sp_q == SPW'(STACK_DEPTH));
  assign empty  = (sp_q == '0);
  assign rd_idx = IW'(sp_q - 1'b1);
  // A push on a full stack lands on the top entry instead of past it
  assign wr_idx = full ? IW'(STACK_DEPTH - 1) : sp_q[IW-1:0];

  always_comb begin
    sel_flag = 1'b1;
    unique case (cond_sel)
      2'd0: sel_flag = 1'b1;
      2'd1: sel_flag = flags[0];
      2'd2: sel_flag = flags[1];
      2'd3: sel_flag = flags[2];
    endcase
  end

  assign cond = sel_flag ^ cond_inv;

`ifdef MICROSEQ_STACK_CHECK_EN
  logic err_q, trap;

  assign trap = !stall && !err_q && cond &&
                ((op == OP_CJS && full) ||
                 (op == OP_CRTN && empty));
  assign hold = stall | err_q | trap;
  assign err  = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | trap;
  end
`else
  assign hold = stall;
  assign err  = 1'b0;
`endif

  always_comb begin
    upc_d = upc_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (!hold) begin
      unique case (op)
        OP_CONT: upc_d = inc;
        OP_JMAP: upc_d = map_addr;
        OP_CJP:  upc_d = cond ? br_addr : inc;
        OP_CJS: begin
          if (cond) begin
            push  = 1'b1;
            upc_d = br_addr;
            if (!full) sp_d = sp_q + 1'b1;
          end else begin
            upc_d = inc;
          end
        end
        OP_CRTN: begin
          if (cond && !empty) begin
            upc_d = stk_q[rd_idx];
            sp_d  = sp_q - 1'b1;
          end else begin
            upc_d = inc;
          end
        end
        OP_LDCT: begin
          cnt_d = br_addr[CNT_W-1:0];
          upc_d = inc;
        end
        OP_RPCT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            upc_d = br_addr;
          end else begin
            upc_d = inc;
          end
        end
        OP_JZ: begin
          upc_d = ADDR_W'(RESET_VEC);
          sp_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upc_q <= ADDR_W'(RESET_VEC);
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      upc_q <= upc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage needs no reset: entries above sp are never read
  always_ff @(posedge clock) begin
    if (push) stk_q[wr_idx] <= inc;
  end

  assign upc       = upc_q;
  assign stk_depth = sp_q;
  assign cnt_zero  = (cnt_q == '0);

endmodule

// File: tb/tb_microseq_ctrl.sv
// tb_microseq_ctrl: vector table, hand sequences and randomized run vs a queue model.
// Build with MICROSEQ_STACK_CHECK_EN to check the stack-error variant.
module tb_microseq_ctrl;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  localparam logic [2:0] CONT = 3'd0, JMAP = 3'd1, CJP = 3'd2, CJS = 3'd3;
  localparam logic [2:0] CRTN = 3'd4, LDCT = 3'd5, RPCT = 3'd6, JZ = 3'd7;

  logic          clock = 1'b0;
  logic          reset, stall, cond_inv;
  logic [2:0]    seq_op, flags;
  logic [1:0]    cond_sel;
  logic [AW-1:0] br_addr, map_addr, upc;
  logic [2:0]    stk_depth;
  logic          cnt_zero, err;

  microseq_ctrl #(
    .ADDR_W(AW), .CNT_W(8), .STACK_DEPTH(DEPTH), .RESET_VEC(0)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .seq_op(seq_op), .cond_sel(cond_sel), .cond_inv(cond_inv),
    .flags(flags), .br_addr(br_addr), .map_addr(map_addr),
    .upc(upc), .stk_depth(stk_depth), .cnt_zero(cnt_zero), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] op;
    logic [1:0] sel;
    logic       inv;
    logic [2:0] fl;
    logic [7:0] br;
    logic [7:0] map;
    logic       st;
    int         e_upc;
    int         e_d;
    int         e_cz;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int   m_upc, m_cnt, m_err;
  int   m_stk[$];

  task automatic add(input logic [2:0] op, input logic [1:0] sel,
                     input logic inv, input logic [2:0] fl,
                     input logic [7:0] br, input logic [7:0] map,
                     input logic st, input int eu, input int ed,
                     input int ecz);
    vec_t v;
    v.op = op; v.sel = sel; v.inv = inv; v.fl = fl;
    v.br = br; v.map = map; v.st = st;
    v.e_upc = eu; v.e_d = ed; v.e_cz = ecz;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int eu, input int ed,
                       input int ecz, input int eerr);
    n_vec++;
    if (upc !== 8'(eu) || stk_depth !== 3'(ed) ||
        cnt_zero !== 1'(ecz) || err !== 1'(eerr)) begin
      n_bad++;
      $display("FAIL %s: got upc=%h depth=%0d cz=%b err=%b, want upc=%h depth=%0d cz=%0d err=%0d",
               nm, upc, stk_depth, cnt_zero, err, 8'(eu), ed, ecz, eerr);
    end
  endtask

  task automatic model_reset();
    m_upc = 0;
    m_cnt = 0;
    m_err = 0;
    m_stk.delete();
  endtask

  // Spec-level behaviour: stack is a plain queue, counter a plain int
  task automatic model_step();
    int c, inc;
    if (stall || m_err != 0) return;
    c   = (cond_sel == 0) ? 1 : int'(flags[cond_sel - 1]);
    c   = c ^ int'(cond_inv);
    inc = (m_upc + 1) % (1 << AW);
    case (seq_op)
      CONT: m_upc = inc;
      JMAP: m_upc = int'(map_addr);
      CJP:  m_upc = (c != 0) ? int'(br_addr) : inc;
      CJS: begin
        if (c != 0) begin
          if (m_stk.size() == DEPTH) begin
`ifdef MICROSEQ_STACK_CHECK_EN
            m_err = 1;
            return;
`else
            m_stk[DEPTH-1] = inc;
`endif
          end else begin
            m_stk.push_back(inc);
          end
          m_upc = int'(br_addr);
        end else begin
          m_upc = inc;
        end
      end
      CRTN: begin
        if (c != 0 && m_stk.size() > 0) begin
          m_upc = m_stk.pop_back();
        end else begin
`ifdef MICROSEQ_STACK_CHECK_EN
          if (c != 0) begin
            m_err = 1;
            return;
          end
`endif
          m_upc = inc;
        end
      end
      LDCT: begin
        m_cnt = int'(br_addr);
        m_upc = inc;
      end
      RPCT: begin
        if (m_cnt != 0) begin
          m_cnt = m_cnt - 1;
          m_upc = int'(br_addr);
        end else begin
          m_upc = inc;
        end
      end
      default: begin
        m_upc = 0;
        m_stk.delete();
      end
    endcase
  endtask

  task automatic apply(input logic [2:0] op, input logic [1:0] sel,
                       input logic inv, input logic [2:0] fl,
                       input logic [7:0] br, input logic [7:0] map,
                       input logic st);
    seq_op = op; cond_sel = sel; cond_inv = inv; flags = fl;
    br_addr = br; map_addr = map; stall = st;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic hv(input string nm, input logic [2:0] op,
                    input logic [1:0] sel, input logic [7:0] br,
                    input logic [7:0] map, input int eu, input int ed,
                    input int ecz, input int eerr);
    apply(op, sel, 1'b0, 3'b000, br, map, 1'b0);
    check(nm, eu, ed, ecz, eerr);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    model_reset();
    #1 check("rst_async", 0, 0, 1, 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; seq_op = CONT; cond_sel = 2'd0;
    cond_inv = 1'b0; flags = 3'b000; br_addr = '0; map_addr = '0;
    model_reset();

    repeat (2500) @(posedge clock);
    #1 check("rst_hold_a", 0, 0, 1, 0);
    repeat (2500) @(posedge clock);
    #1 check("rst_hold_b", 0, 0, 1, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 check("rst_release", 0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      apply(CONT, 2'd0, 1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
      check("rst_cont", i, 0, 1, 0);
    end

    add(CONT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h04, 0, 1);
    add(CONT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h05, 0, 1);
    add(CJP,  1, 0, 3'b001, 8'h40, 8'h00, 0, 'h40, 0, 1);
    add(JMAP, 0, 0, 3'b000, 8'h00, 8'h05, 0, 'h05, 0, 1);
    add(CJP,  1, 0, 3'b000, 8'h40, 8'h00, 0, 'h06, 0, 1);
    add(JMAP, 0, 0, 3'b000, 8'h00, 8'h05, 0, 'h05, 0, 1);
    add(CJP,  1, 1, 3'b001, 8'h40, 8'h00, 0, 'h06, 0, 1);
    add(JMAP, 0, 0, 3'b000, 8'h00, 8'h05, 0, 'h05, 0, 1);
    add(CJP,  1, 1, 3'b000, 8'h40, 8'h00, 0, 'h40, 0, 1);
    add(CJP,  2, 0, 3'b010, 8'h50, 8'h00, 0, 'h50, 0, 1);
    add(CJP,  3, 0, 3'b011, 8'h60, 8'h00, 0, 'h51, 0, 1);
    add(CJP,  3, 0, 3'b100, 8'h60, 8'h00, 0, 'h60, 0, 1);
    add(JMAP, 0, 0, 3'b000, 8'h00, 8'h10, 0, 'h10, 0, 1);
    add(CJS,  0, 0, 3'b000, 8'h80, 8'h00, 0, 'h80, 1, 1);
    add(CRTN, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h11, 0, 1);
    add(CJS,  1, 0, 3'b000, 8'h80, 8'h00, 0, 'h12, 0, 1);
    add(CJS,  1, 0, 3'b001, 8'h80, 8'h00, 0, 'h80, 1, 1);
    add(CRTN, 2, 0, 3'b000, 8'h00, 8'h00, 0, 'h81, 1, 1);
    add(CRTN, 2, 0, 3'b010, 8'h00, 8'h00, 0, 'h13, 0, 1);
    add(LDCT, 0, 0, 3'b000, 8'h03, 8'h00, 0, 'h14, 0, 0);
    add(JMAP, 0, 0, 3'b000, 8'h00, 8'h21, 0, 'h21, 0, 0);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 0, 'h20, 0, 0);
    add(CONT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h21, 0, 0);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 0, 'h20, 0, 0);
    add(CONT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h21, 0, 0);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 0, 'h20, 0, 1);
    add(CONT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h21, 0, 1);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 0, 'h22, 0, 1);
    add(JMAP, 0, 0, 3'b000, 8'h00, 8'h9C, 0, 'h9C, 0, 1);
    add(JMAP, 0, 0, 3'b000, 8'h00, 8'hFF, 0, 'hFF, 0, 1);
    add(CONT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h00, 0, 1);
    add(LDCT, 0, 0, 3'b000, 8'h02, 8'h00, 0, 'h01, 0, 0);
    add(JMAP, 0, 0, 3'b000, 8'h00, 8'h21, 0, 'h21, 0, 0);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 1, 'h21, 0, 0);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 1, 'h21, 0, 0);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 1, 'h21, 0, 0);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 0, 'h20, 0, 0);
    add(CONT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h21, 0, 0);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 0, 'h20, 0, 1);
    add(CONT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h21, 0, 1);
    add(RPCT, 0, 0, 3'b000, 8'h20, 8'h00, 0, 'h22, 0, 1);
    add(CJS,  0, 0, 3'b000, 8'h44, 8'h00, 0, 'h44, 1, 1);
    add(LDCT, 0, 0, 3'b000, 8'h05, 8'h00, 0, 'h45, 1, 0);
    add(JZ,   0, 0, 3'b000, 8'h00, 8'h00, 0, 'h00, 0, 0);
    add(CONT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h01, 0, 0);
    add(JZ,   0, 0, 3'b000, 8'h00, 8'h00, 1, 'h01, 0, 0);
    add(JZ,   0, 0, 3'b000, 8'h00, 8'h00, 0, 'h00, 0, 0);
    add(LDCT, 0, 0, 3'b000, 8'h00, 8'h00, 0, 'h01, 0, 1);
    add(RPCT, 0, 0, 3'b000, 8'h70, 8'h00, 0, 'h02, 0, 1);

    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].sel, tbl[i].inv, tbl[i].fl,
            tbl[i].br, tbl[i].map, tbl[i].st);
      check($sformatf("tbl[%0d]", i), tbl[i].e_upc, tbl[i].e_d,
            tbl[i].e_cz, 0);
    end

    hv("nest_map", JMAP, 0, 8'h00, 8'h30, 'h30, 0, 1, 0);
    hv("nest_c1", CJS, 0, 8'h40, 8'h00, 'h40, 1, 1, 0);
    hv("nest_c2", CJS, 0, 8'h50, 8'h00, 'h50, 2, 1, 0);
    hv("nest_c3", CJS, 0, 8'h60, 8'h00, 'h60, 3, 1, 0);
    hv("nest_c4", CJS, 0, 8'h70, 8'h00, 'h70, 4, 1, 0);
    hv("nest_r4", CRTN, 0, 8'h00, 8'h00, 'h61, 3, 1, 0);
    hv("nest_r3", CRTN, 0, 8'h00, 8'h00, 'h51, 2, 1, 0);
    hv("nest_r2", CRTN, 0, 8'h00, 8'h00, 'h41, 1, 1, 0);
    hv("nest_r1", CRTN, 0, 8'h00, 8'h00, 'h31, 0, 1, 0);
    hv("ovf_c1", CJS, 0, 8'h40, 8'h00, 'h40, 1, 1, 0);
    hv("ovf_c2", CJS, 0, 8'h50, 8'h00, 'h50, 2, 1, 0);
    hv("ovf_c3", CJS, 0, 8'h60, 8'h00, 'h60, 3, 1, 0);
    hv("ovf_c4", CJS, 0, 8'h70, 8'h00, 'h70, 4, 1, 0);
`ifdef MICROSEQ_STACK_CHECK_EN
    hv("ovf_c5", CJS, 0, 8'h90, 8'h00, 'h70, 4, 1, 1);
    hv("ovf_frz_a", CONT, 0, 8'h00, 8'h00, 'h70, 4, 1, 1);
    hv("ovf_frz_b", JMAP, 0, 8'h00, 8'h11, 'h70, 4, 1, 1);
    do_reset();
    hv("unf_rtn", CRTN, 0, 8'h00, 8'h00, 'h00, 0, 1, 1);
    hv("unf_frz", CONT, 0, 8'h00, 8'h00, 'h00, 0, 1, 1);
    do_reset();
`else
    hv("ovf_c5", CJS, 0, 8'h90, 8'h00, 'h90, 4, 1, 0);
    hv("ovf_r5", CRTN, 0, 8'h00, 8'h00, 'h71, 3, 1, 0);
    hv("ovf_r3", CRTN, 0, 8'h00, 8'h00, 'h51, 2, 1, 0);
    hv("ovf_r2", CRTN, 0, 8'h00, 8'h00, 'h41, 1, 1, 0);
    hv("ovf_r1", CRTN, 0, 8'h00, 8'h00, 'h32, 0, 1, 0);
    hv("unf_rtn", CRTN, 0, 8'h00, 8'h00, 'h33, 0, 1, 0);
`endif

    hv("mid_cjs", CJS, 0, 8'h50, 8'h00, 'h50, 1, 1, 0);
    hv("mid_ldct", LDCT, 0, 8'h05, 8'h00, 'h51, 1, 0, 0);
    apply(RPCT, 2'd0, 1'b0, 3'b000, 8'h20, 8'h00, 1'b1);
    check("mid_stall", 'h51, 1, 0, 0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(7));
      if (op == JZ && $urandom_range(3) != 0) op = CONT;
      apply(op, 2'($urandom_range(3)), 1'($urandom_range(1)),
            3'($urandom_range(7)), 8'($urandom_range(255)),
            8'($urandom_range(255)), ($urandom_range(7) == 0));
      check($sformatf("rand[%0d]", i), m_upc, m_stk.size(),
            int'(m_cnt == 0), m_err);
      if (m_err != 0 || $urandom_range(199) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
